// File: rtl/maxpool_wb.sv
// maxpool_wb: 2x2 stride-2 max pooling of a raster conv-output stream into the output buffer.
// Define MAXPOOL_WB_RELU_EN to clamp negative pooled values to zero on write.
`timescale 1ns/1ps
module maxpool_wb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int PLANES = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              neu_valid,
  input  logic [DATA_W-1:0] neu_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              plane_done,
  output logic              all_done,
  output logic              busy
);
  localparam int HW      = IMG_W / 2;
  localparam int POOL_SZ = HW * (IMG_H / 2);
  localparam int CW      = $clog2(IMG_W);
  localparam int RW      = $clog2(IMG_H);
  localparam int PW      = $clog2(PLANES + 1);
  localparam int LW      = HW > 1 ? $clog2(HW) : 1;
  if (IMG_W % 2 != 0 || IMG_H % 2 != 0) begin : g_odd_dims
    $error("maxpool_wb: IMG_W and IMG_H must be even");
  end
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [PW-1:0]     plane;
  logic [ADDR_W-1:0] pidx, base;
  logic [DATA_W-1:0] pair;
  logic [DATA_W-1:0] linebuf [HW];
  logic [LW-1:0]     lb_idx;
  logic [DATA_W-1:0] hmax, fin, res;
  logic              accept, last_col, last_row;
  // plane reaching PLANES marks the one-cycle drain before busy drops
  always_comb begin
    accept   = neu_valid & busy & ~start & (plane != PW'(PLANES));
    last_col = col == CW'(IMG_W - 1);
    last_row = row == RW'(IMG_H - 1);
    lb_idx   = LW'(col >> 1);
    hmax     = $signed(neu_data) > $signed(pair) ? neu_data : pair;
    fin      = $signed(linebuf[lb_idx]) > $signed(hmax) ? linebuf[lb_idx] : hmax;
`ifdef MAXPOOL_WB_RELU_EN
    res      = fin[DATA_W-1] ? '0 : fin;
`else
    res      = fin;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {col, row, plane, pidx, base, pair} <= '0;
      {wr_en, wr_addr, wr_data, plane_done, all_done, busy} <= '0;
      for (int i = 0; i < HW; i++) linebuf[i] <= '0;
    end else begin
      wr_en      <= 1'b0;
      plane_done <= 1'b0;
      if (start) begin
        {col, row, plane, pidx, base} <= '0;
        all_done <= 1'b0;
        busy     <= 1'b1;
      end else if (busy && plane == PW'(PLANES)) begin
        busy     <= 1'b0;
        all_done <= 1'b1;
      end else if (accept) begin
        if (!col[0]) pair <= neu_data;
        else if (!row[0]) linebuf[lb_idx] <= hmax;
        else begin
          wr_en   <= 1'b1;
          wr_addr <= base + pidx;
          wr_data <= res;
          pidx    <= pidx + ADDR_W'(1);
        end
        col <= last_col ? '0 : col + CW'(1);
        if (last_col) row <= last_row ? '0 : row + RW'(1);
        if (last_col && last_row) begin
          pidx       <= '0;
          base       <= base + ADDR_W'(POOL_SZ);
          plane      <= plane + PW'(1);
          plane_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_maxpool_wb.sv
// tb_maxpool_wb: randomized scoreboard bench for maxpool_wb against a plain image-array pooling model.
`timescale 1ns/1ps
module tb_maxpool_wb;
  localparam int DW = 16, AW = 16, W = 28, H = 28, P = 6, PS = (W / 2) * (H / 2);
  logic clk = 0, rst_n = 0, start = 0, neu_valid = 0;
  logic [DW-1:0] neu_data = '0;
  logic wr_en, plane_done, all_done, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  maxpool_wb dut (
    .clk(clk), .rst_n(rst_n), .start(start), .neu_valid(neu_valid), .neu_data(neu_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .plane_done(plane_done), .all_done(all_done), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic pd;
    logic last;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t got;
  int checks = 0, errors = 0, cyc = 0;
  logic chk_done = 0;
  logic signed [DW-1:0] img [H][W];
  logic [DW-1:0] negs [6] = '{16'h8000, 16'hFFFF, 16'h0000, 16'hFFFD, 16'h7FFF, 16'h0001};
  logic [DW-1:0] wv [4] = '{16'hFFFD, 16'hFFFF, 16'hFFF9, 16'hFFFE};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (chk_done) begin
      chk_done = 0;
      chk("all_done_after_last", all_done, 1);
      chk("busy_after_last", busy, 0);
    end
    if (wr_en && q.size() == 0) chk("unexpected_write", wr_en, 0);
    else if (wr_en) begin
      got = q.pop_front();
      chk("wr_addr", wr_addr, got.addr);
      chk("wr_data", wr_data, got.data);
      chk("plane_done", plane_done, got.pd);
      chk("write_latency", cyc, got.cyc);
      if (got.last) chk_done = 1;
    end else if (plane_done) chk("stray_plane_done", plane_done, 0);
  end
  task automatic feed(input int npix, input int pat, input int duty, input bit model);
    for (int n = 0; n < npix; n++) begin
      int p, r, c;
      logic signed [DW-1:0] v, m;
      exp_t e;
      p = n / (W * H);
      r = (n / W) % H;
      c = n % W;
      case (pat)
        0: v = DW'(r * W + c);
        1: v = 5;
        2: v = DW'($urandom);
        3: v = negs[$urandom_range(5)];
        default: v = wv[(r % 2) * 2 + c % 2];
      endcase
      img[r][c] = v;
      do begin
        @(negedge clk);
        neu_valid = ($urandom_range(99) < duty);
        neu_data = DW'($urandom);
      end while (!neu_valid);
      neu_data = v;
      if (model && r % 2 == 1 && c % 2 == 1) begin
        m = img[r-1][c-1];
        if (img[r-1][c] > m) m = img[r-1][c];
        if (img[r][c-1] > m) m = img[r][c-1];
        if (img[r][c] > m) m = img[r][c];
`ifdef MAXPOOL_WB_RELU_EN
        if (m < 0) m = 0;
`endif
        e.addr = AW'(p * PS + (r / 2) * (W / 2) + c / 2);
        e.data = m;
        e.pd = (r == H - 1) && (c == W - 1);
        e.last = e.pd && (p == P - 1);
        e.cyc = cyc + 1;
        q.push_back(e);
      end
    end
    @(negedge clk);
    neu_valid = 0;
  endtask
  task automatic do_start(input bit with_valid);
    @(negedge clk);
    start = 1;
    neu_valid = with_valid;
    neu_data = DW'($urandom);
    @(negedge clk);
    start = 0;
    neu_valid = 0;
    chk("busy_after_start", busy, 1);
    chk("all_done_cleared", all_done, 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_plane_done"}, plane_done, 0);
    chk({tag, "_all_done"}, all_done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish by 2ms");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    feed(20, 2, 100, 0);
    chk("idle_ignores_valid", busy, 0);
    do_start(0);
    feed(P * W * H, 0, 100, 1);
    drain();
    do_start(0);
    feed(P * W * H, 1, 100, 1);
    drain();
    do_start(0);
    feed(W * H, 4, 100, 1);
    drain();
    do_start(0);
    feed(P * W * H, 3, 50, 1);
    drain();
    do_start(0);
    feed(P * W * H, 2, 50, 1);
    drain();
    do_start(0);
    feed(2 * W * H + 400, 2, 100, 1);
    drain();
    do_start(1);
    feed(P * W * H, 2, 70, 1);
    drain();
    do_start(0);
    feed(300, 2, 100, 1);
    drain();
    #2;
    rst_n = 0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1;
    feed(W * H, 2, 100, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_all_done", all_done, 0);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
